// File: rtl/proj_kmer_extractor_if.sv
// Handshake bundle between a base-stream source and the k-mer extractor.
// The master modport belongs to the source of bases, which is also the k-mer consumer.
interface proj_kmer_extractor_if #(
  parameter int BASE_BITS        = 2,
  parameter int HASHER_DATA_BITS = 32,
  parameter int POS_BITS         = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic [BASE_BITS-1:0]        in_base;
  logic                        in_n;
  logic                        in_start;
  logic                        in_last;
  logic                        kmer_valid;
  logic                        kmer_ready;
  logic [HASHER_DATA_BITS-1:0] kmer;
  logic [POS_BITS-1:0]         kmer_pos;
  logic                        seq_done;
  logic [POS_BITS-1:0]         kmer_count;

  modport master (
    output in_valid, in_base, in_n, in_start, in_last, kmer_ready,
    input  in_ready, kmer_valid, kmer, kmer_pos, seq_done, kmer_count
  );

  modport slave (
    input  in_valid, in_base, in_n, in_start, in_last, kmer_ready,
    output in_ready, kmer_valid, kmer, kmer_pos, seq_done, kmer_count
  );
endinterface

// File: rtl/proj_kmer_extractor.sv
// Sliding-window k-mer extractor: one base per cycle in, one packed k-mer out 1 cycle after the completing base.
// Backpressure: a held k-mer stalls input (in_ready low) unless idle; a simultaneous drain and new k-mer keeps full rate.
module proj_kmer_extractor #(
  parameter int KMER_LEN         = 16,
  parameter int BASE_BITS        = 2,
  parameter int HASHER_DATA_BITS = 32,
  parameter int POS_BITS         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  proj_kmer_extractor_if.slave  io
);
  localparam int WIN_W  = KMER_LEN * BASE_BITS;
  localparam int FILL_W = $clog2(KMER_LEN + 1);
  localparam logic [FILL_W-1:0]   FULL    = FILL_W'(KMER_LEN);
  localparam logic [POS_BITS-1:0] POS_OFS = POS_BITS'(KMER_LEN - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t              state, state_nxt;
  logic [WIN_W-1:0]    window, window_nxt;
  logic [FILL_W-1:0]   fill, fill_nxt, fill_base;
  logic [POS_BITS-1:0] base_cnt, base_idx;
  logic [POS_BITS-1:0] kmer_cnt, kmer_cnt_nxt;
  logic                accept, active, emit;

  assign io.in_ready = (state == IDLE) || !io.kmer_valid || io.kmer_ready;
  assign accept      = io.in_valid && io.in_ready;
  // Bases outside a sequence are dropped; in_start always opens a new one.
  assign active      = accept && (io.in_start || (state != IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    window_nxt   = window;
    fill_nxt     = fill;
    emit         = 1'b0;
    base_idx     = io.in_start ? '0 : base_cnt;
    fill_base    = io.in_start ? '0 : fill;
    kmer_cnt_nxt = io.in_start ? '0 : kmer_cnt;
    if (active) begin
      if (io.in_n) begin
        fill_nxt  = '0;
        state_nxt = FILL;
      end else begin
        window_nxt = {window[WIN_W-BASE_BITS-1:0], io.in_base};
        fill_nxt   = (fill_base == FULL) ? FULL : fill_base + 1'b1;
        emit       = (fill_nxt == FULL);
        state_nxt  = emit ? STREAM : FILL;
      end
      if (emit) begin
        kmer_cnt_nxt = kmer_cnt_nxt + 1'b1;
      end
      if (io.in_last) begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window        <= '0;
      fill          <= '0;
      base_cnt      <= '0;
      kmer_cnt      <= '0;
      io.kmer_valid <= 1'b0;
      io.kmer       <= '0;
      io.kmer_pos   <= '0;
      io.seq_done   <= 1'b0;
      io.kmer_count <= '0;
    end else begin
      io.seq_done <= 1'b0;
      if (active) begin
        window   <= window_nxt;
        fill     <= fill_nxt;
        base_cnt <= base_idx + 1'b1;
        kmer_cnt <= kmer_cnt_nxt;
        if (io.in_last) begin
          io.seq_done   <= 1'b1;
          io.kmer_count <= kmer_cnt_nxt;
        end
      end
      // emit only happens when the held word is draining or absent, so nothing is overwritten
      if (emit) begin
        io.kmer_valid <= 1'b1;
        io.kmer       <= HASHER_DATA_BITS'(window_nxt);
        io.kmer_pos   <= base_idx - POS_OFS;
      end else if (io.kmer_ready) begin
        io.kmer_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/proj_kmer_extractor.md
Name: proj_kmer_extractor

Overview:
Front end of the MinHash datapath. Accepts a serial stream of encoded DNA bases and maintains a sliding window of KMER_LEN bases. Emits every complete k-mer, packed into a HASHER_DATA_BITS word, over a valid/ready handshake. The output feeds the kmer input of the proj_hasher bank. Also reports each k-mer's position and a per-sequence k-mer count.

Parameters:
KMER_LEN, 16 (proj_pkg::KMER_LEN), bases per k-mer; 2..HASHER_DATA_BITS/BASE_BITS.
BASE_BITS, 2 (proj_pkg::BASE_LEN), bits per base code (A=0, C=1, G=2, T=3).
HASHER_DATA_BITS, 32 (proj_pkg::HASHER_SORTER_SIGNATURE), output word width.
POS_BITS, 16, width of the position and count fields.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  base present
in_ready  out  1  extractor can accept a base
in_base  in  BASE_BITS  base code
in_n  in  1  ambiguous base ('N'); in_base ignored
in_start  in  1  base is the first of a new sequence
in_last  in  1  base is the last of the sequence
kmer_valid  out  1  kmer word valid
kmer_ready  in  1  downstream (hasher) accepts
kmer  out  HASHER_DATA_BITS  packed k-mer: oldest base in MSBs of the low KMER_LEN*BASE_BITS bits, upper bits zero
kmer_pos  out  POS_BITS  sequence index of the k-mer's first base
seq_done  out  1  one-cycle pulse: sequence finished
kmer_count  out  POS_BITS  k-mers emitted for the finished sequence; valid with seq_done

Behaviour:
- accept = in_valid & in_ready. in_ready = !kmer_valid | kmer_ready (combinational). in_ready is also 1 in IDLE.
- Reset: asynchronous, effective immediately. kmer_valid=0, kmer=0, kmer_pos=0, seq_done=0, kmer_count=0. Window, fill counter, base counter and k-mer counter are all 0. State = IDLE.
- States:
  - IDLE: accepted bases without in_start are discarded. An accepted base with in_start moves to FILL.
  - FILL: window holds fewer than KMER_LEN valid bases.
  - STREAM: window is full; every accepted non-N base emits a k-mer.
- Window update on accept of a non-N base: window <= {window[(KMER_LEN-1)*BASE_BITS-1:0], in_base}. fill = min(fill+1, KMER_LEN).
- in_start on accept: base counter, fill and k-mer counter restart at this base (it is index 0, fill becomes 1, or 0 if in_n). This overrides any sequence in progress; the aborted sequence gets no seq_done.
- in_n on accept: fill=0, state=FILL, no k-mer emitted, base counter still increments.
- Emission: when an accept makes fill reach or stay at KMER_LEN, the next cycle has kmer_valid=1, kmer=new window, kmer_pos=base_index-(KMER_LEN-1). Latency is 1 cycle from accept. The k-mer counter increments.
- Output holding: kmer, kmer_pos and kmer_valid hold until kmer_ready. A simultaneous kmer_ready and new accept replaces the output register in the same edge, so one base/cycle throughput is sustained.
- in_last on accept: seq_done pulses one cycle later, with kmer_count equal to the total including the k-mer produced by this base. State returns to IDLE.
  - seq_done does not wait for the final k-mer handshake; the k-mer may still be pending.
  - in_start & in_last together: a 1-base sequence, seq_done with count 0 (count 1 if KMER_LEN would be 1, which is disallowed).
- Width rules: base counter and kmer_count wrap modulo 2^POS_BITS; no saturation flag.
- Reset asserted mid-stream: pending kmer is dropped, and no seq_done is issued.

Test Plan:
(Tests use KMER_LEN=4, BASE_BITS=2, HASHER_DATA_BITS=32, kmer_ready=1 unless stated.)
1. Basic stream A,C,G,T,A,C (start on A, last on C), one base/cycle.
   - Required: kmers 0x0000001B pos 0, 0x0000006C pos 1, 0x000000B1 pos 2, on consecutive cycles.
   - Then seq_done pulse with kmer_count=3.
2. Backpressure: same stream, kmer_ready held 0 for 3 cycles after the first kmer_valid.
   - Required: kmer stays 0x1B and in_ready stays 0 throughout.
   - After release, all three kmers arrive with none lost or duplicated.
3. Ambiguous base: A,C,G,N,T,A,C,G (last on G).
   - Required: a single kmer 0x000000C6 at pos 4.
   - seq_done with kmer_count=1.
4. Short sequence: A,C,G with in_last on G.
   - Required: no kmer_valid.
   - seq_done one cycle after G, with kmer_count=0.
5. Restart: in_start asserted on the 6th base of an unfinished sequence.
   - Required: no seq_done for the old sequence.
   - The new sequence's first kmer appears after 4 bases, at pos 0.
6. Reset with kmer_valid=1 and kmer_ready=0: pulse rst_n low asynchronously.
   - Required: kmer_valid=0 and kmer=0 immediately; state IDLE.
   - Bases without in_start afterwards are discarded.
